// File: rtl/clk_period_monitor_pkg.sv
// Shared types and constants for the divided-clock period monitor.
// DIV_HALF matches the divider so both ends agree on the nominal period.
package clk_period_monitor_pkg;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } mon_state_t;

    localparam int unsigned DIV_HALF        = 250000;
    localparam int unsigned EXPECTED_PERIOD = 2 * DIV_HALF;
    localparam int unsigned DEFAULT_CNT_W   = 20;

    // Inclusive tolerance window; the lower bound clamps at zero.
    function automatic logic in_window(input logic [31:0] meas,
                                       input int unsigned expected,
                                       input int unsigned tol);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = (expected > tol) ? expected - tol : 32'd0;
        hi = expected + tol;
        return (meas >= lo) && (meas <= hi);
    endfunction

endpackage

// File: rtl/clk_period_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus delay flop; emits a combinational rise and a
// registered one-cycle rise strobe for any asynchronous input.
module clk_period_monitor_sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic rise_pulse
);

    logic s1;
    logic s2;
    logic s3;

    assign rise = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            s1         <= async_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= rise;
        end
    end

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous slow clock in fast-clock cycles,
// tracks lock against a tolerance window and flags missing edges.
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int unsigned EXPECTED_PERIOD = clk_period_monitor_pkg::EXPECTED_PERIOD,
    parameter int unsigned TOLERANCE       = 16,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned MAX_PERIOD      = 1048575,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned       GOOD_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_PERIOD);
    localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_COUNT);

    mon_state_t        state;
    mon_state_t        state_next;
    logic              rise;
    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_inc;
    logic              hit_max;
    logic              meas_good;
    logic              arm;
    logic              load_period;
    logic              do_timeout;

    clk_period_monitor_sync_edge_detect u_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (clk_in),
        .rise       (rise),
        .rise_pulse (rise_pulse)
    );

    // The counter holds cycles since the last rise, so +1 is the period.
    assign cnt_inc   = counter + CNT_W'(1);
    assign hit_max   = (cnt_inc == MAX_CNT);
    assign meas_good = in_window(32'(period), EXPECTED_PERIOD, TOLERANCE);
    assign good_inc  = (good_cnt == LOCK_CNT) ? LOCK_CNT : good_cnt + GOOD_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_FIRST;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FIRST: if (rise)       state_next = MEASURE;
            MEASURE:    if (do_timeout) state_next = WAIT_FIRST;
            default:                    state_next = WAIT_FIRST;
        endcase
    end

    // A rise always beats the timeout threshold in the same cycle.
    always_comb begin
        arm         = 1'b0;
        load_period = 1'b0;
        do_timeout  = 1'b0;
        case (state)
            WAIT_FIRST: arm = rise;
            MEASURE: begin
                load_period = rise;
                do_timeout  = ~rise & hit_max;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            good_cnt     <= '0;
        end else begin
            period_valid <= load_period;
            // Lock is judged from the registered period, one cycle after it lands.
            if (period_valid) begin
                if (meas_good) begin
                    good_cnt <= good_inc;
                    locked   <= (good_inc == LOCK_CNT);
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
            if (arm) begin
                counter <= '0;
                timeout <= 1'b0;
            end else if (load_period) begin
                counter <= '0;
                period  <= cnt_inc;
            end else if (do_timeout) begin
                counter  <= '0;
                timeout  <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
            end else if (state == MEASURE) begin
                counter <= cnt_inc;
            end else begin
                counter <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: directed table, hand corner sequences and
// random waves, all checked against a cycle-level reference model.
module tb_clk_period_monitor;

    localparam int EXP   = 10;
    localparam int TOL   = 1;
    localparam int LOCKC = 3;
    localparam int MAXP  = 32;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_in;
    logic          rise_pulse;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int dut_last_rise = 0;

    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] sb_exp;
    bit            sb_on = 1'b0;

    typedef struct {
        int len;
        bit report;
        bit chk;
        bit exp_lock;
    } row_t;

    row_t tbl [19];

    clk_period_monitor #(
        .EXPECTED_PERIOD (EXP),
        .TOLERANCE       (TOL),
        .LOCK_COUNT      (LOCKC),
        .MAX_PERIOD      (MAXP),
        .CNT_W           (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_in       (clk_in),
        .rise_pulse   (rise_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    // clock / watchdog
    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // reference model: rise seen 3 edges after clk_in goes high; period = cycles between rises
    bit            samp_h [4];
    bit            rst_h  [4];
    bit            m_rise, m_pv, m_locked, m_timeout, m_have_ref, m_pend;
    int            m_good, m_last, m_pend_p;
    logic [CW-1:0] m_period;

    initial begin
        int lo;
        int hi;
        lo = (EXP > TOL) ? EXP - TOL : 0;
        hi = EXP + TOL;
        m_period = '0;
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 3; k > 0; k--) begin
                samp_h[k] = samp_h[k-1];
                rst_h[k]  = rst_h[k-1];
            end
            rst_h[0]  = reset;
            samp_h[0] = clk_in & ~reset;
            m_rise = !rst_h[0] && !rst_h[1] && samp_h[2] && !samp_h[3];
            if (rst_h[0]) begin
                m_have_ref = 0; m_pend = 0; m_good = 0;
                m_locked = 0; m_timeout = 0; m_pv = 0; m_period = '0;
            end else begin
                m_pv = 0;
                if (m_pend) begin
                    if (m_pend_p >= lo && m_pend_p <= hi) begin
                        m_good   = (m_good + 1 > LOCKC) ? LOCKC : m_good + 1;
                        m_locked = (m_good == LOCKC);
                    end else begin
                        m_good   = 0;
                        m_locked = 0;
                    end
                    m_pend = 0;
                end
                if (m_rise) begin
                    if (m_have_ref) begin
                        m_pend_p = cyc - m_last;
                        m_period = CW'(m_pend_p);
                        m_pv     = 1;
                        m_pend   = 1;
                    end else begin
                        m_have_ref = 1;
                        m_timeout  = 0;
                    end
                    m_last = cyc;
                end else if (m_have_ref && (cyc - m_last == MAXP)) begin
                    m_timeout = 1; m_locked = 0; m_good = 0; m_have_ref = 0;
                end
            end
            @(negedge clk);
            if (rise_pulse === 1'b1) dut_last_rise = cyc;
            check("outputs", {rise_pulse, period_valid, period, locked, timeout},
                  {m_rise, m_pv, m_period, m_locked, m_timeout});
        end
    end

    // scoreboard for table-driven periods
    initial forever begin
        @(negedge clk);
        if (sb_on && period_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected cyc=%0d got=%0d want=none", cyc, period);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_period", period, sb_exp);
            end
        end
    end

    // driver: one clk_in period of len cycles, high for hi cycles
    task automatic drive_wave(input int len, input int hi, input bit chk,
                              input bit exp_lock, input bit push);
        if (push) exp_q.push_back(CW'(len));
        for (int j = 0; j < len; j++) begin
            if (chk && j == 4) check("lock_after_rise", locked, exp_lock);
            clk_in = (j < hi);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit got;
        int pv_cnt;
        int r;
        int len;

        tbl = '{'{10,1,1,0}, '{10,1,1,0}, '{10,1,1,0}, '{10,1,1,1}, '{13,1,1,1},
                '{10,1,1,0}, '{10,1,1,0}, '{10,1,1,0}, '{ 9,1,1,1}, '{11,1,1,1},
                '{ 8,1,1,1}, '{10,1,1,0}, '{10,1,1,0}, '{10,1,1,0}, '{12,1,1,1},
                '{10,1,1,0}, '{10,1,1,0}, '{10,1,1,0}, '{10,0,1,1}};

        reset  = 1'b1;
        clk_in = 1'b0;
        idle(3);
        check("reset_state", {rise_pulse, period_valid, period, locked, timeout}, 0);
        reset = 1'b0;
        idle(4);

        // table: lock, single bad period, tolerance boundaries
        sb_on = 1'b1;
        for (int i = 0; i < 19; i++)
            drive_wave(tbl[i].len, tbl[i].len / 2, tbl[i].chk, tbl[i].exp_lock, tbl[i].report);
        sb_on = 1'b0;
        check("sb_drain", exp_q.size(), 0);

        // hold low until timeout
        clk_in = 1'b0;
        got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(posedge clk); #1;
            if (timeout === 1'b1) got = 1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_wait cyc=%0d got=no_timeout want=timeout", cyc);
        end else begin
            check("timeout_latency", cyc - dut_last_rise, MAXP);
            check("timeout_locked", locked, 0);
        end
        idle(5);

        // resume: first rise is reference only
        drive_wave(10, 5, 1, 0, 0);
        check("timeout_clear", timeout, 0);
        drive_wave(10, 5, 1, 0, 0);
        drive_wave(10, 5, 1, 0, 0);
        drive_wave(10, 5, 1, 1, 0);

        // reset mid-period while locked
        clk_in = 1'b1;
        idle(5);
        clk_in = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        check("reset_mid", {rise_pulse, period_valid, period, locked, timeout}, 0);
        reset = 1'b0;
        idle(3);
        drive_wave(10, 5, 1, 0, 0);
        drive_wave(10, 5, 1, 0, 0);
        drive_wave(10, 5, 1, 0, 0);
        drive_wave(10, 5, 1, 1, 0);

        // clk_in high across reset release
        clk_in = 1'b1;
        reset  = 1'b1;
        idle(3);
        reset  = 1'b0;
        pv_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (period_valid === 1'b1) pv_cnt++;
        end
        check("spurious_no_pv", pv_cnt, 0);
        check("spurious_no_lock", locked, 0);
        clk_in = 1'b0;
        idle(3);
        drive_wave(10, 5, 1, 0, 0);
        drive_wave(10, 5, 1, 0, 0);

        // rise landing exactly on the timeout threshold
        drive_wave(MAXP, MAXP / 2, 0, 0, 0);
        drive_wave(MAXP, MAXP / 2, 0, 0, 0);
        drive_wave(10, 5, 0, 0, 0);

        // random waves and resets
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                len = $urandom_range(EXP - TOL, EXP + TOL);
            end else if (r < 8) begin
                len = $urandom_range(2, 20);
            end else if (r == 8) begin
                len = $urandom_range(30, 40);
            end else begin
                reset  = 1'b1;
                clk_in = 1'($urandom_range(0, 1));
                idle($urandom_range(1, 3));
                reset  = 1'b0;
                len    = EXP;
            end
            drive_wave(len, $urandom_range(1, len - 1), 0, 0, 0);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
